ram_arbiter2: RTL and testbench

- Two-requester arbiter/sequencer in front of the 16x8 synchronous RAM.
- RAM interface being driven:
  - write-enable priority: a write cycle performs no read;
  - registered read data, one-cycle latency;
  - separate write and read address ports.
- Each requester issues single read or write transactions over a req/ack handshake.
- Round-robin arbitration gives fair access when both requesters contend.

---
 rtl/ram_arbiter2_if.sv | 44 ++++
 rtl/ram_arbiter2.sv | 115 +++++++++++
 tb/tb_ram_arbiter2.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter2_if.sv
// Bundle of the two requester ports and the RAM-side signals of ram_arbiter2.
// The slave modport is the arbiter's view; master is the requesters plus RAM.
interface ram_arbiter2_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
);
  logic          req0;
  logic          wr0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          wr1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_inaddr;
  logic [AW-1:0] mem_outaddr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  req0, wr0, addr0, wdata0,
    output ack0, rdata0,
    input  req1, wr1, addr1, wdata1,
    output ack1, rdata1,
    output mem_we, mem_inaddr, mem_outaddr, mem_din,
    input  mem_dout
  );

  modport master (
    output req0, wr0, addr0, wdata0,
    input  ack0, rdata0,
    output req1, wr1, addr1, wdata1,
    input  ack1, rdata1,
    input  mem_we, mem_inaddr, mem_outaddr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/ram_arbiter2.sv
// Two-port round-robin arbiter/sequencer in front of a synchronous RAM with
// registered read data. One transaction is in flight at a time, so a write
// followed by a read of the same address always returns the new data.
module ram_arbiter2 #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter2_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCapture, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          grant;

  // Next-state logic: arbitration and command latch in idle, then sequencing.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    grant        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // On contention the port that was not served last wins.
          grant        = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
          owner_d      = grant;
          last_grant_d = grant;
          wr_d         = grant ? bus.wr1    : bus.wr0;
          addr_d       = grant ? bus.addr1  : bus.addr0;
          wdata_d      = grant ? bus.wdata1 : bus.wdata0;
          state_d      = wr_d ? StWrite : StRead;
        end
      end
      StWrite: begin
        state_d = StDone;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        if (owner_q) rdata1_d = bus.mem_dout;
        else         rdata0_d = bus.mem_dout;
        state_d = StDone;
        ack0_d  = ~owner_q;
        ack1_d  = owner_q;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; ack is registered so it lines up with DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  // RAM drive comes straight from the latched command so requester inputs
  // cannot disturb an in-flight transaction; mem_we drops with async reset.
  assign bus.mem_we      = (state_q == StWrite);
  assign bus.mem_inaddr  = addr_q;
  assign bus.mem_outaddr = addr_q;
  assign bus.mem_din     = wdata_q;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter2.sv
// Self-checking bench for ram_arbiter2: behavioural 16x8 RAM, table of single
// transactions, plus contention, reset-abort and late input change sequences.
module tb_ram_arbiter2;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int Budget = 20;
  localparam logic [7:0] InitMem [16] = '{
    8'h11, 8'h32, 8'h53, 8'h74, 8'h95, 8'hB6, 8'hD7, 8'hF8,
    8'h19, 8'h3A, 8'h5B, 8'h7C, 8'h9D, 8'hBE, 8'hDF, 8'hF0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter2_if #(.AW(AW), .DW(DW)) bus ();
  ram_arbiter2 #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Behavioural RAM: write has priority, read data registered.
  logic [7:0] ram [16] = InitMem;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_inaddr] <= bus.mem_din;
    else            bus.mem_dout <= ram[bus.mem_outaddr];
  end

  typedef struct {
    bit         port;
    bit         rd;
    logic [7:0] data;
  } sb_t;

  typedef struct {
    bit         port;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    bit         chg;
    logic [3:0] addr2;
    logic [7:0] wdata2;
    int         exp_lat;
  } vec_t;

  sb_t        sbq[$];
  logic [7:0] sh [16] = InitMem;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops the scoreboard; both rdata ports are checked
  // against the model so the non-owner port is proven untouched.
  initial begin
    sb_t        item;
    logic [7:0] exp_rd0 = '0;
    logic [7:0] exp_rd1 = '0;
    bit         prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rd0  = '0;
        exp_rd1  = '0;
        prev_ack = 1'b0;
      end else begin
        if (bus.ack0 || bus.ack1) begin
          check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
          check("ack_single_pulse", 32'(prev_ack), 32'd0);
          if (sbq.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
          end else begin
            item = sbq.pop_front();
            check("ack_port", 32'(bus.ack1), 32'(item.port));
            if (item.rd) begin
              if (item.port) exp_rd1 = item.data;
              else           exp_rd0 = item.data;
            end
            check("rdata0", 32'(bus.rdata0), 32'(exp_rd0));
            check("rdata1", 32'(bus.rdata1), 32'(exp_rd1));
          end
        end
        prev_ack = bus.ack0 | bus.ack1;
      end
    end
  end

  task automatic set_req(input bit p, input bit v);
    if (p) bus.req1 = v;
    else   bus.req0 = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
  endtask

  // One transaction from IDLE; checks RAM drive per cycle and ack latency.
  task automatic run_txn(input vec_t v);
    int  k;
    bit  got;
    bit  ackp;
    @(posedge clk);
    #1;
    if (v.port) begin
      bus.req1 = 1'b1; bus.wr1 = v.wr; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1'b1; bus.wr0 = v.wr; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end
    sbq.push_back('{port: v.port, rd: !v.wr, data: sh[v.addr]});
    if (v.wr) sh[v.addr] = v.wdata;
    k = 0;
    got = 1'b0;
    while (!got && k < Budget) begin
      @(negedge clk);
      check($sformatf("mem_we c%0d", k), 32'(bus.mem_we), 32'(v.wr && k == 1));
      if (k == 1) begin
        if (v.wr) begin
          check("mem_inaddr", 32'(bus.mem_inaddr), 32'(v.addr));
          check("mem_din", 32'(bus.mem_din), 32'(v.wdata));
        end else begin
          check("mem_outaddr", 32'(bus.mem_outaddr), 32'(v.addr));
        end
      end
      ackp = v.port ? bus.ack1 : bus.ack0;
      if (ackp) begin
        got = 1'b1;
        check("ack_latency", 32'(k), 32'(v.exp_lat));
        set_req(v.port, 1'b0);
      end
      if (k == 0 && v.chg) begin
        // Just after the grant edge: disturb the requester inputs.
        @(posedge clk);
        #1;
        if (v.port) begin bus.addr1 = v.addr2; bus.wdata1 = v.wdata2; end
        else        begin bus.addr0 = v.addr2; bus.wdata0 = v.wdata2; end
      end
      k++;
    end
    if (!got) begin
      check("ack_timeout", 32'd0, 32'd1);
      set_req(v.port, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [11];
    int   n0;
    int   n1;
    int   k;
    vec_t v;

    vecs[0]  = '{0, 1, 4'd3,  8'hA5, 0, 4'd0, 8'h00, 2};
    vecs[1]  = '{1, 0, 4'd3,  8'h00, 0, 4'd0, 8'h00, 3};
    vecs[2]  = '{0, 1, 4'd15, 8'h3C, 0, 4'd0, 8'h00, 2};
    vecs[3]  = '{0, 0, 4'd15, 8'h00, 0, 4'd0, 8'h00, 3};
    vecs[4]  = '{0, 0, 4'd0,  8'h00, 0, 4'd0, 8'h00, 3};
    vecs[5]  = '{1, 1, 4'd0,  8'h5A, 0, 4'd0, 8'h00, 2};
    vecs[6]  = '{0, 0, 4'd0,  8'h00, 0, 4'd0, 8'h00, 3};
    vecs[7]  = '{1, 0, 4'd8,  8'h00, 0, 4'd0, 8'h00, 3};
    vecs[8]  = '{0, 1, 4'd2,  8'hC3, 1, 4'd9, 8'hFF, 2};
    vecs[9]  = '{1, 0, 4'd2,  8'h00, 0, 4'd0, 8'h00, 3};
    vecs[10] = '{0, 0, 4'd9,  8'h00, 0, 4'd0, 8'h00, 3};

    rst = 1'b1;
    bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_rdata0", 32'(bus.rdata0), 32'd0);
    check("rst_rdata1", 32'(bus.rdata1), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_inaddr", 32'(bus.mem_inaddr), 32'd0);
    check("rst_mem_din", 32'(bus.mem_din), 32'd0);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Contention straight out of reset: both read, both held for two each.
    do_reset();
    bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 4'd3;
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 4'd15;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sbq.push_back('{port: 1'b0, rd: 1'b1, data: sh[3]});
      else            sbq.push_back('{port: 1'b1, rd: 1'b1, data: sh[15]});
    end
    n0 = 0;
    n1 = 0;
    k = 0;
    while (n0 + n1 < 4 && k < 4 * Budget) begin
      @(negedge clk);
      if (bus.ack0) begin
        if (n0 + n1 == 0) check("contend_first_latency", 32'(k), 32'd3);
        n0++;
        if (n0 == 2) bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        n1++;
        if (n1 == 2) bus.req1 = 1'b0;
      end
      k++;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("contend_ack_count", 32'(n0 + n1), 32'd4);
    check("contend_port0_count", 32'(n0), 32'd2);

    // Reset while a write is in WRITE: mem_we falls at once, no ack, no write.
    @(posedge clk);
    #1;
    sbq.delete();
    bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 4'd7; bus.wdata0 = 8'h77;
    @(posedge clk);
    #1;
    check("abort_we_in_write", 32'(bus.mem_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_we_drop", 32'(bus.mem_we), 32'd0);
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ack", 32'(bus.ack0 | bus.ack1), 32'd0);
    end
    v = '{1, 0, 4'd7, 8'h00, 0, 4'd0, 8'h00, 3};
    run_txn(v);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
